// File: rtl/sram_fifo_pkg.sv
// ---------------------------------------------------------------------------
// sram_fifo_pkg: shared sizing for the SRAM-backed FIFO controller. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package sram_fifo_pkg;

  localparam int DATA_W       = 14;
  localparam int ADDR_W       = 7;
  localparam int DEPTH        = 128;
  localparam int CNT_W        = 8;
  localparam int OUTBUF_DEPTH = 2;
  localparam int OCC_W        = $clog2(OUTBUF_DEPTH + 1);

endpackage

`default_nettype wire

// File: rtl/sram_fifo_ctrl_if.sv
// ---------------------------------------------------------------------------
// sram_fifo_ctrl_if: producer/consumer stream bundle of the FIFO. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface sram_fifo_ctrl_if #(
  parameter int DATA_W = sram_fifo_pkg::DATA_W,
  parameter int CNT_W  = sram_fifo_pkg::CNT_W
) ();

  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  count;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, count
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, count
  );

endinterface

`default_nettype wire

// File: rtl/sram_fifo_outbuf.sv
// ---------------------------------------------------------------------------
// sram_fifo_outbuf: two-entry in-order skid buffer at the FIFO head. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_fifo_outbuf #(
  parameter int DATA_W = sram_fifo_pkg::DATA_W
) (
  input  wire logic                           clk,
  input  wire logic                           rst,
  input  wire logic                           push,
  input  wire logic [DATA_W-1:0]              push_data,
  input  wire logic                           pop,
  output logic [sram_fifo_pkg::OCC_W-1:0]     occ,
  output logic [DATA_W-1:0]                   head_data
);
  import sram_fifo_pkg::*;

  logic [DATA_W-1:0] r_mem [OUTBUF_DEPTH];
  logic              r_wr_sel;
  logic              r_rd_sel;
  logic [OCC_W-1:0]  r_occ;

  // Callers never push into a full buffer without popping in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_sel <= 1'b0;
      r_rd_sel <= 1'b0;
      r_occ    <= '0;
    end else begin
      if (push) r_wr_sel <= ~r_wr_sel;
      if (pop)  r_rd_sel <= ~r_rd_sel;
      case ({push, pop})
        2'b10:   r_occ <= r_occ + OCC_W'(1);
        2'b01:   r_occ <= r_occ - OCC_W'(1);
        default: r_occ <= r_occ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) r_mem[r_wr_sel] <= push_data;
  end

  assign occ       = r_occ;
  assign head_data = r_mem[r_rd_sel];

endmodule

`default_nettype wire

// File: rtl/sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// sram_fifo_ctrl: valid/ready FIFO over a 1W1R SRAM macro plus 2-entry head
// buffer. Optional macro SRAM_FIFO_BYPASS_EN enables empty-FIFO bypass. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module sram_fifo_ctrl #(
  parameter int DATA_W = sram_fifo_pkg::DATA_W,
  parameter int ADDR_W = sram_fifo_pkg::ADDR_W,
  parameter int DEPTH  = sram_fifo_pkg::DEPTH,
  parameter int CNT_W  = sram_fifo_pkg::CNT_W
) (
  input  wire logic              clk,
  input  wire logic              rst,
  sram_fifo_ctrl_if.slave        bus,
  output logic                   sram_csb0,
  output logic [ADDR_W-1:0]      sram_addr0,
  output logic [DATA_W-1:0]      sram_din0,
  output logic                   sram_csb1,
  output logic [ADDR_W-1:0]      sram_addr1,
  input  wire logic [DATA_W-1:0] sram_dout1
);
  import sram_fifo_pkg::*;

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam int               c_sum_w = OCC_W + 1;

  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]   r_sram_cnt;
  logic               r_inflight;

  logic [OCC_W-1:0]   w_out_occ;
  logic [DATA_W-1:0]  w_head;
  logic               w_accept;
  logic               w_bypass;
  logic               w_wr_en;
  logic               w_issue;
  logic               w_push;
  logic               w_pop;
  logic [DATA_W-1:0]  w_push_data;
  logic [c_sum_w-1:0] w_used;
  logic [c_sum_w-1:0] w_limit;

  assign bus.in_ready = !rst && (r_sram_cnt < c_depth);
  assign w_accept     = bus.in_valid && bus.in_ready;

`ifdef SRAM_FIFO_BYPASS_EN
  // Nothing older is in the SRAM or in flight, so the word may skip the macro.
  assign w_bypass = w_accept && (r_sram_cnt == '0) && !r_inflight &&
                    (w_out_occ < OCC_W'(OUTBUF_DEPTH));
`else
  assign w_bypass = 1'b0;
`endif

  assign w_wr_en = w_accept && !w_bypass;

  // A head word popped this cycle frees its slot, which keeps reads streaming
  // at one per cycle while the consumer is ready.
  assign w_pop   = bus.out_valid && bus.out_ready;
  assign w_used  = c_sum_w'(w_out_occ) + c_sum_w'(r_inflight);
  assign w_limit = c_sum_w'(OUTBUF_DEPTH) + c_sum_w'(w_pop);
  assign w_issue = !rst && (r_sram_cnt != '0) && (w_used < w_limit);

  assign w_push      = r_inflight || w_bypass;
  assign w_push_data = r_inflight ? sram_dout1 : bus.in_data;

  assign sram_csb0  = !w_wr_en;
  assign sram_addr0 = r_wr_ptr;
  assign sram_din0  = bus.in_data;
  assign sram_csb1  = !w_issue;
  assign sram_addr1 = r_rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_sram_cnt <= '0;
      r_inflight <= 1'b0;
    end else begin
      if (w_wr_en) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_issue) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      r_inflight <= w_issue;
      case ({w_wr_en, w_issue})
        2'b10:   r_sram_cnt <= r_sram_cnt + CNT_W'(1);
        2'b01:   r_sram_cnt <= r_sram_cnt - CNT_W'(1);
        default: r_sram_cnt <= r_sram_cnt;
      endcase
    end
  end

  sram_fifo_outbuf #(
    .DATA_W (DATA_W)
  ) u_outbuf (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .push_data (w_push_data),
    .pop       (w_pop),
    .occ       (w_out_occ),
    .head_data (w_head)
  );

  assign bus.out_valid = !rst && (w_out_occ != '0);
  assign bus.out_data  = w_head;
  assign bus.count     = rst ? '0 :
                         r_sram_cnt + CNT_W'(r_inflight) + CNT_W'(w_out_occ);

endmodule

`default_nettype wire

// File: tb/tb_sram_fifo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_fifo_ctrl: self-checking bench with a behavioural 1W1R SRAM model
// and a queue reference model of the FIFO contents. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_sram_fifo_ctrl;
  import sram_fifo_pkg::*;

`ifdef SRAM_FIFO_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 3;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sram_fifo_ctrl_if #(.DATA_W(DATA_W), .CNT_W(CNT_W)) bus ();

  logic              sram_csb0, sram_csb1;
  logic [ADDR_W-1:0] sram_addr0, sram_addr1;
  logic [DATA_W-1:0] sram_din0, sram_dout1;

  sram_fifo_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .sram_csb0  (sram_csb0),
    .sram_addr0 (sram_addr0),
    .sram_din0  (sram_din0),
    .sram_csb1  (sram_csb1),
    .sram_addr1 (sram_addr1),
    .sram_dout1 (sram_dout1)
  );

  // Behavioural macro: address captured at the edge, data held until next read.
  logic [DATA_W-1:0] sram_mem [DEPTH];
  int sim_conflicts = 0;
  always @(posedge clk) begin
    if (!sram_csb0) sram_mem[sram_addr0] <= sram_din0;
    if (!sram_csb1) sram_dout1 <= sram_mem[sram_addr1];
    if (!sram_csb0 && !sram_csb1 && sram_addr0 == sram_addr1)
      sim_conflicts <= sim_conflicts + 1;
  end

  int checks = 0;
  int failures = 0;
  logic [DATA_W-1:0] model_q [$];
  int n_pop = 0;
  bit wrap0, wrap1;
  logic [ADDR_W-1:0] last_a0 = '0, last_a1 = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s: bound expired at %0t", name, $time);
  endtask

  task automatic drive(input logic r, input logic iv, input logic [DATA_W-1:0] d, input logic ordy);
    rst           = r;
    bus.in_valid  = iv;
    bus.in_data   = d;
    bus.out_ready = ordy;
  endtask

  // Sample once per cycle; the queue holds every accepted, not yet popped word.
  task automatic settle();
    logic [DATA_W-1:0] exp_word;
    #1;
    if (rst) begin
      model_q.delete();
    end else begin
      check("count_vs_model", 32'(bus.count), 32'(model_q.size()));
      if (bus.out_valid && bus.out_ready) begin
        if (model_q.size() == 0) begin
          fail_now("pop_from_empty");
        end else begin
          exp_word = model_q.pop_front();
          check("out_data_order", 32'(bus.out_data), 32'(exp_word));
        end
        n_pop++;
      end
      if (bus.in_valid && bus.in_ready) model_q.push_back(bus.in_data);
      if (!sram_csb0) begin
        if (last_a0 == ADDR_W'(DEPTH - 1) && sram_addr0 == '0) wrap0 = 1'b1;
        last_a0 = sram_addr0;
      end
      if (!sram_csb1) begin
        if (last_a1 == ADDR_W'(DEPTH - 1) && sram_addr1 == '0) wrap1 = 1'b1;
        last_a1 = sram_addr1;
      end
    end
  endtask

  task automatic step();
    settle();
    @(negedge clk);
  endtask

  task automatic drain(input string name);
    for (int k = 0; k < 600 && model_q.size() > 0; k++) begin
      drive(0, 0, '0, 1);
      step();
    end
    if (model_q.size() != 0) fail_now(name);
    drive(0, 0, '0, 1);
    settle();
    check({name, ".out_valid"}, 32'(bus.out_valid), 0);
    check({name, ".count"}, 32'(bus.count), 0);
    @(negedge clk);
  endtask

  typedef struct {
    logic              rst, iv;
    logic [DATA_W-1:0] d;
    logic              ordy;
    logic              e_inr, e_csb0;
    logic [ADDR_W-1:0] e_a0;
    logic              e_csb1;
    logic [ADDR_W-1:0] e_a1;
    logic              e_ov;
    logic [DATA_W-1:0] e_od;
    logic [CNT_W-1:0]  e_cnt;
  } vec_t;

  function automatic vec_t v(input logic r, input logic iv, input logic [DATA_W-1:0] d,
                             input logic ordy, input logic inr, input logic csb0,
                             input logic [ADDR_W-1:0] a0, input logic csb1,
                             input logic [ADDR_W-1:0] a1, input logic ov,
                             input logic [DATA_W-1:0] od, input logic [CNT_W-1:0] cnt);
    vec_t t;
    t.rst = r; t.iv = iv; t.d = d; t.ordy = ordy; t.e_inr = inr; t.e_csb0 = csb0;
    t.e_a0 = a0; t.e_csb1 = csb1; t.e_a1 = a1; t.e_ov = ov; t.e_od = od; t.e_cnt = cnt;
    return t;
  endfunction

  vec_t tbl [$];

  initial begin
    int accepted;
    int seen;
    int pushed;
    logic [DATA_W-1:0] wd;

    drive(1, 0, '0, 0);
    @(negedge clk);

    //       rst iv data    ordy inr csb0 a0 csb1 a1 ov od      cnt
    tbl.push_back(v(1, 1, 'h1111, 1, 0, 1, 0, 1, 0, 0, 0,       0));
`ifdef SRAM_FIFO_BYPASS_EN
    tbl.push_back(v(0, 1, 'h1ABC, 1, 1, 1, 0, 1, 0, 0, 0,       0));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 1, 'h1ABC,  1));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 0, 0,       0));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 0, 0,       0));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 0, 0,       0));
    tbl.push_back(v(0, 1, 'h0011, 1, 1, 1, 0, 1, 0, 0, 0,       0));
    tbl.push_back(v(0, 1, 'h0022, 1, 1, 1, 0, 1, 0, 1, 'h0011,  1));
    tbl.push_back(v(0, 1, 'h0033, 1, 1, 1, 0, 1, 0, 1, 'h0022,  1));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 1, 'h0033,  1));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 0, 0,       0));
`else
    tbl.push_back(v(0, 1, 'h1ABC, 1, 1, 0, 0, 1, 0, 0, 0,       0));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 0, 0, 0, 0,       1));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 0, 0,       1));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 1, 'h1ABC,  1));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 0, 0,       0));
    tbl.push_back(v(0, 1, 'h0011, 1, 1, 0, 1, 1, 0, 0, 0,       0));
    tbl.push_back(v(0, 1, 'h0022, 1, 1, 0, 2, 0, 1, 0, 0,       1));
    tbl.push_back(v(0, 1, 'h0033, 1, 1, 0, 3, 0, 2, 0, 0,       2));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 0, 3, 1, 'h0011,  3));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 1, 'h0022,  2));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 1, 'h0033,  1));
    tbl.push_back(v(0, 0, 'h0000, 1, 1, 1, 0, 1, 0, 0, 0,       0));
`endif

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].rst, tbl[i].iv, tbl[i].d, tbl[i].ordy);
      settle();
      check($sformatf("vec%0d.in_ready", i),  32'(bus.in_ready),  32'(tbl[i].e_inr));
      check($sformatf("vec%0d.csb0", i),      32'(sram_csb0),     32'(tbl[i].e_csb0));
      check($sformatf("vec%0d.csb1", i),      32'(sram_csb1),     32'(tbl[i].e_csb1));
      check($sformatf("vec%0d.out_valid", i), 32'(bus.out_valid), 32'(tbl[i].e_ov));
      check($sformatf("vec%0d.count", i),     32'(bus.count),     32'(tbl[i].e_cnt));
      if (!tbl[i].e_csb0) begin
        check($sformatf("vec%0d.addr0", i), 32'(sram_addr0), 32'(tbl[i].e_a0));
        check($sformatf("vec%0d.din0", i),  32'(sram_din0),  32'(tbl[i].d));
      end
      if (!tbl[i].e_csb1) check($sformatf("vec%0d.addr1", i), 32'(sram_addr1), 32'(tbl[i].e_a1));
      if (tbl[i].e_ov)    check($sformatf("vec%0d.out_data", i), 32'(bus.out_data), 32'(tbl[i].e_od));
      @(negedge clk);
    end

    // Stalled consumer: capacity is SRAM depth plus the two head slots.
    accepted = 0;
    for (int k = 0; k < 140; k++) begin
      drive(0, 1, DATA_W'(accepted), 0);
      settle();
      if (bus.in_ready) accepted++;
      @(negedge clk);
    end
    check("full.accepted", 32'(accepted), 32'(DEPTH + 2));
    drive(0, 1, DATA_W'(accepted), 0);
    settle();
    check("full.in_ready", 32'(bus.in_ready), 0);
    check("full.count", 32'(bus.count), 32'(DEPTH + 2));
    check("full.out_valid", 32'(bus.out_valid), 1);
    @(negedge clk);
    drain("full_drain");

    // Random traffic across pointer wrap.
    wrap0 = 1'b0;
    wrap1 = 1'b0;
    n_pop = 0;
    pushed = 0;
    for (int k = 0; k < 5000 && (pushed < 300 || model_q.size() > 0); k++) begin
      wd = DATA_W'($urandom);
      drive(0, (pushed < 300) && ($urandom_range(3) != 0), wd, 1'($urandom_range(1)));
      settle();
      if (bus.in_valid && bus.in_ready) pushed++;
      @(negedge clk);
    end
    if (model_q.size() != 0 || pushed != 300) fail_now("wrap_traffic");
    check("wrap.popped", 32'(n_pop), 300);
    check("wrap.addr0_wrapped", 32'(wrap0), 1);
    check("wrap.addr1_wrapped", 32'(wrap1), 1);

    // Steady push and pop at half depth.
    for (int k = 0; k < 200 && model_q.size() < 64; k++) begin
      drive(0, 1, DATA_W'($urandom), 0);
      step();
    end
    for (int k = 0; k < 4; k++) begin
      drive(0, 0, '0, 0);
      step();
    end
    for (int k = 0; k < 50; k++) begin
      drive(0, 1, DATA_W'($urandom), 1);
      settle();
      check($sformatf("steady%0d.count", k), 32'(bus.count), 64);
      check($sformatf("steady%0d.csb0", k), 32'(sram_csb0), 0);
      check($sformatf("steady%0d.csb1", k), 32'(sram_csb1), 0);
      @(negedge clk);
    end
    drain("steady_drain");

    // Reset while a read is in flight; stale read data must not surface.
    drive(0, 1, 'h0AAA, 0);
    step();
    drive(0, 0, '0, 0);
    settle();
`ifndef SRAM_FIFO_BYPASS_EN
    check("rst_seq.issue_csb1", 32'(sram_csb1), 0);
`endif
    @(negedge clk);
    drive(1, 1, 'h0333, 1);
    settle();
    check("rst_seq.out_valid", 32'(bus.out_valid), 0);
    check("rst_seq.count", 32'(bus.count), 0);
    check("rst_seq.csb0", 32'(sram_csb0), 1);
    check("rst_seq.csb1", 32'(sram_csb1), 1);
    check("rst_seq.in_ready", 32'(bus.in_ready), 0);
    @(negedge clk);
    drive(0, 1, 'h0005, 1);
    settle();
    check("post_rst.out_valid", 32'(bus.out_valid), 0);
    check("post_rst.count", 32'(bus.count), 0);
`ifdef SRAM_FIFO_BYPASS_EN
    check("post_rst.csb0", 32'(sram_csb0), 1);
`else
    check("post_rst.csb0", 32'(sram_csb0), 0);
    check("post_rst.addr0", 32'(sram_addr0), 0);
`endif
    @(negedge clk);
    seen = 0;
    for (int k = 1; k <= 10 && seen == 0; k++) begin
      drive(0, 0, '0, 1);
      settle();
      if (bus.out_valid) begin
        seen = 1;
        check("post_rst.latency", 32'(k), 32'(LAT));
        check("post_rst.first_word", 32'(bus.out_data), 'h0005);
      end
      @(negedge clk);
    end
    if (seen == 0) fail_now("post_rst.out_valid_wait");
    drain("post_rst_drain");

    check("macro_same_addr_conflicts", 32'(sim_conflicts), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
